// File: rtl/sc_chain_loader.sv
// Configuration scan-chain loader: serialises handshaked words into the sc_dff chain
// and repacks the bits leaving the chain tail into readback words.
module sc_chain_loader #(
    parameter int WORD_WIDTH = 8,
    parameter int CHAIN_LEN  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  word_valid,
    input  logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_ready,
    output logic                  sc_head,
    output logic                  sc_en,
    input  logic                  sc_tail,
    output logic                  rb_valid,
    output logic [WORD_WIDTH-1:0] rb_data,
    output logic                  busy,
    output logic                  done
);

    localparam int BW = $clog2(WORD_WIDTH);
    localparam int TW = $clog2(CHAIN_LEN + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_WIDTH - 1);
    localparam logic [TW-1:0] TOT_LAST = TW'(CHAIN_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state, state_d;
    logic [WORD_WIDTH-1:0] shreg;
    logic [WORD_WIDTH-1:0] rb_reg;
    logic [WORD_WIDTH-1:0] rb_word;
    logic [BW-1:0]         bit_cnt;
    logic [TW-1:0]         total_cnt;

    // sc_head comes straight from the shift register flop, so it is registered.
    assign sc_head = shreg[0];

    always_comb begin
        rb_word          = rb_reg;
        rb_word[bit_cnt] = sc_tail;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start && !abort) state_d = S_FETCH;
            S_FETCH: begin
                if (abort)                         state_d = S_IDLE;
                else if (word_valid && word_ready) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (abort)                     state_d = S_IDLE;
                else if (total_cnt == TOT_LAST) state_d = S_DONE;
                else if (bit_cnt == BIT_LAST)   state_d = S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            rb_reg     <= '0;
            bit_cnt    <= '0;
            total_cnt  <= '0;
            word_ready <= 1'b0;
            sc_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rb_valid   <= 1'b0;
            rb_data    <= '0;
        end else begin
            state      <= state_d;
            word_ready <= (state_d == S_FETCH);
            sc_en      <= (state_d == S_SHIFT);
            busy       <= (state_d != S_IDLE);
            done       <= (state_d == S_DONE);
            rb_valid   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (state_d == S_FETCH) begin
                        bit_cnt   <= '0;
                        total_cnt <= '0;
                        rb_reg    <= '0;
                    end
                end
                S_FETCH: begin
                    if (state_d == S_SHIFT) shreg <= word_data;
                end
                S_SHIFT: begin
                    if (!abort) begin
                        shreg     <= shreg >> 1;
                        total_cnt <= total_cnt + TW'(1);
                        if (state_d == S_SHIFT) begin
                            bit_cnt <= bit_cnt + BW'(1);
                            rb_reg  <= rb_word;
                        end else begin
                            // word boundary or final bit: publish and restart packing
                            rb_valid <= 1'b1;
                            rb_data  <= rb_word;
                            rb_reg   <= '0;
                            bit_cnt  <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_chain_loader.sv
// Directed bench for sc_chain_loader: one instance per chain length, each driving
// a behavioural chain model whose bit 0 is the tail flip-flop.
module tb_sc_chain_loader;

    logic        clk, reset, start, abort, word_valid, sel;
    logic [7:0]  word_data;
    logic        pre_a, pre_b;
    logic [19:0] pre_val;

    logic        word_ready_a, sc_head_a, sc_en_a, rb_valid_a, busy_a, done_a;
    logic        word_ready_b, sc_head_b, sc_en_b, rb_valid_b, busy_b, done_b;
    logic [7:0]  rb_data_a, rb_data_b;
    logic [15:0] chain_a;
    logic [19:0] chain_b;

    logic        word_ready, sc_head, sc_en, rb_valid, busy, done;
    logic [7:0]  rb_data;

    int          errors, checks;
    int          n_busy, n_done, n_en, n_rb;
    logic [31:0] head_bits;
    logic [7:0]  rb_log [4];

    sc_chain_loader #(.WORD_WIDTH(8), .CHAIN_LEN(16)) dut_a (
        .clk(clk), .reset(reset), .start(start & ~sel), .abort(abort & ~sel),
        .word_valid(word_valid & ~sel), .word_data(word_data), .word_ready(word_ready_a),
        .sc_head(sc_head_a), .sc_en(sc_en_a), .sc_tail(chain_a[0]),
        .rb_valid(rb_valid_a), .rb_data(rb_data_a), .busy(busy_a), .done(done_a));

    sc_chain_loader #(.WORD_WIDTH(8), .CHAIN_LEN(20)) dut_b (
        .clk(clk), .reset(reset), .start(start & sel), .abort(abort & sel),
        .word_valid(word_valid & sel), .word_data(word_data), .word_ready(word_ready_b),
        .sc_head(sc_head_b), .sc_en(sc_en_b), .sc_tail(chain_b[0]),
        .rb_valid(rb_valid_b), .rb_data(rb_data_b), .busy(busy_b), .done(done_b));

    assign word_ready = sel ? word_ready_b : word_ready_a;
    assign sc_head    = sel ? sc_head_b    : sc_head_a;
    assign sc_en      = sel ? sc_en_b      : sc_en_a;
    assign rb_valid   = sel ? rb_valid_b   : rb_valid_a;
    assign rb_data    = sel ? rb_data_b    : rb_data_a;
    assign busy       = sel ? busy_b       : busy_a;
    assign done       = sel ? done_b       : done_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_a)        chain_a <= pre_val[15:0];
        else if (sc_en_a) chain_a <= {sc_head_a, chain_a[15:1]};
        if (pre_b)        chain_b <= pre_val;
        else if (sc_en_b) chain_b <= {sc_head_b, chain_b[19:1]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (busy) n_busy++;
        if (done) n_done++;
        if (sc_en) begin
            if (n_en < 32) head_bits[n_en] = sc_head;
            n_en++;
        end
        if (rb_valid) begin
            if (n_rb < 4) rb_log[n_rb] = rb_data;
            n_rb++;
        end
    endtask

    task automatic clr();
        n_busy = 0; n_done = 0; n_en = 0; n_rb = 0; head_bits = '0;
        for (int i = 0; i < 4; i++) rb_log[i] = '0;
    endtask

    function automatic logic pick(input int which);
        case (which)
            0:       return word_ready;
            1:       return sc_en;
            default: return done;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        int t = 0;
        while (!pick(which) && t < 200) begin
            tick();
            t++;
        end
        check(tag, 32'(pick(which)), 32'd1);
    endtask

    task automatic preload(input logic [19:0] v);
        pre_val = v;
        if (sel) pre_b = 1'b1; else pre_a = 1'b1;
        tick();
        pre_a = 1'b0; pre_b = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input int nw, input int stall);
        logic [7:0] w [3];
        w[0] = w0; w[1] = w1; w[2] = w2;
        clr();
        word_data  = w[0];
        word_valid = 1'b1;
        do_start();
        for (int k = 0; k < nw; k++) begin
            wait_for(1, "wait_shift");
            if (k < nw - 1) begin
                if (stall > 0) word_valid = 1'b0;
                else           word_data  = w[k+1];
                wait_for(0, "wait_fetch");
                for (int s = 0; s < stall; s++) begin
                    check("stall_ready", 32'(word_ready), 32'd1);
                    check("stall_sc_en", 32'(sc_en), 32'd0);
                    tick();
                end
                word_data  = w[k+1];
                word_valid = 1'b1;
            end else begin
                word_valid = 1'b0;
            end
        end
        wait_for(2, "wait_done");
        tick();
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b0; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = '0;
        sel = 1'b0; pre_a = 1'b0; pre_b = 1'b0; pre_val = '0;
        clr();

        @(negedge clk);
        pre_a = 1'b1; pre_b = 1'b1; pre_val = '0;
        @(negedge clk);
        pre_a = 1'b0; pre_b = 1'b0;
        check("reset_outputs_a", {word_ready, sc_head, sc_en, rb_valid, busy, done, rb_data}, 32'd0);
        sel = 1'b1;
        #1;
        check("reset_outputs_b", {word_ready, sc_head, sc_en, rb_valid, busy, done, rb_data}, 32'd0);
        sel = 1'b0;
        reset = 1'b1;
        tick(); tick();

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'd0);
        tick();

        // basic two-word load
        run_load(8'hA5, 8'h3C, 8'h00, 2, 0);
        check("t1_chain",    32'(chain_a), 32'h3CA5);
        check("t1_busy_cyc", n_busy, 19);
        check("t1_done_cnt", n_done, 1);
        check("t1_en_cnt",   n_en, 16);
        check("t1_rb_cnt",   n_rb, 2);

        // partial final word, CHAIN_LEN=20
        sel = 1'b1;
        preload(20'hFFFFF);
        run_load(8'hFF, 8'h00, 8'hF7, 3, 0);
        check("t2_en_cnt",   n_en, 20);
        check("t2_head_seq", {12'd0, head_bits[19:0]}, 32'h700FF);
        check("t2_last4",    {28'd0, head_bits[19:16]}, 32'h7);
        check("t2_chain",    {12'd0, chain_b}, 32'h700FF);
        check("t2_rb_cnt",   n_rb, 3);
        check("t2_rb0",      32'(rb_log[0]), 32'hFF);
        check("t2_rb1",      32'(rb_log[1]), 32'hFF);
        check("t2_rb2_pad",  32'(rb_log[2]), 32'h0F);
        check("t2_busy_cyc", n_busy, 24);
        check("t2_done_cnt", n_done, 1);
        sel = 1'b0;

        // readback of previous chain contents
        preload(20'h01234);
        run_load(8'h00, 8'h00, 8'h00, 2, 0);
        check("t3_rb_cnt", n_rb, 2);
        check("t3_rb0",    32'(rb_log[0]), 32'h34);
        check("t3_rb1",    32'(rb_log[1]), 32'h12);
        check("t3_chain",  32'(chain_a), 32'h0000);

        // stall between words
        preload(20'h0);
        run_load(8'hA5, 8'h3C, 8'h00, 2, 5);
        check("t4_chain",    32'(chain_a), 32'h3CA5);
        check("t4_en_cnt",   n_en, 16);
        check("t4_done_cnt", n_done, 1);
        check("t4_busy_cyc", n_busy, 24);

        // abort after 5 shift cycles
        preload(20'h0);
        clr();
        word_data = 8'hA5; word_valid = 1'b1;
        do_start();
        wait_for(1, "t5_wait_shift");
        word_valid = 1'b0;
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy_after_abort", 32'(busy), 32'd0);
        check("t5_en_after_abort",   32'(sc_en), 32'd0);
        check("t5_rdy_after_abort",  32'(word_ready), 32'd0);
        repeat (10) tick();
        check("t5_en_cnt",   n_en, 5);
        check("t5_done_cnt", n_done, 0);
        check("t5_rb_cnt",   n_rb, 0);
        check("t5_chain",    32'(chain_a), 32'h2800);
        run_load(8'hA5, 8'h3C, 8'h00, 2, 0);
        check("t5_reload_chain", 32'(chain_a), 32'h3CA5);
        check("t5_reload_rb0",   32'(rb_log[0]), 32'h00);
        check("t5_reload_rb1",   32'(rb_log[1]), 32'h28);
        check("t5_reload_done",  n_done, 1);

        // asynchronous reset mid-shift
        preload(20'h0);
        clr();
        word_data = 8'hA5; word_valid = 1'b1;
        do_start();
        wait_for(1, "t6_wait_shift");
        tick(); tick();
        check("t6_busy_before_rst", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_async_outputs", {word_ready, sc_head, sc_en, rb_valid, busy, done, rb_data}, 32'd0);
        word_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        preload(20'h0);
        run_load(8'hA5, 8'h3C, 8'h00, 2, 0);
        check("t6_chain",    32'(chain_a), 32'h3CA5);
        check("t6_done_cnt", n_done, 1);
        check("t6_busy_cyc", n_busy, 19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sc_chain_loader.md
# sc_chain_loader

Serializing transmitter for the configuration scan chain. It accepts configuration words over a valid/ready handshake and shifts them bit-serially into a chain of scan-chain flip-flops. In the same shift cycles it captures the bits leaving the chain tail and repacks them into readback words. It sits between the configuration port and the head/tail of the sc_dff chain in the fabric.

## Interface
- WORD_WIDTH, 8: bits per input and readback word, ≥2.
- CHAIN_LEN, 64: number of flip-flops in the chain, ≥1; need not be a multiple of WORD_WIDTH.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous reset, active-low (0 = reset).
- start  input  1  1-cycle request to begin a load; honoured only in IDLE.
- abort  input  1  terminates a load in progress.
- word_valid  input  1  word_data is valid.
- word_data  input  WORD_WIDTH  configuration word, LSB shifted first.
- word_ready  output  1  loader accepts word_data this cycle.
- sc_head  output  1  serial data to the first chain flip-flop.
- sc_en  output  1  chain shift enable; the chain captures sc_head on each clk edge where sc_en=1.
- sc_tail  input  1  output of the last chain flip-flop.
- rb_valid  output  1  1-cycle pulse; rb_data holds a readback word.
- rb_data  output  WORD_WIDTH  readback word, first bit out of the tail in the LSB.
- busy  output  1  high from the cycle after start until DONE is left.
- done  output  1  1-cycle pulse after the last bit has been shifted.

## Operation
- Reset value of every output is 0.
- States: IDLE, FETCH, SHIFT, DONE.
- Internal counters:
  - total_cnt counts shifted bits, 0..CHAIN_LEN.
  - bit_cnt counts bits within the current word.
- IDLE → FETCH on start=1. Clears both counters and the readback register.
- FETCH: word_ready=1.
  - On word_valid & word_ready, latch word_data into the shift register and go to SHIFT.
  - With word_valid=0, stay in FETCH. sc_en stays 0.
- SHIFT, each cycle:
  - sc_en=1 and sc_head=shreg[0].
  - Shift shreg right; increment bit_cnt and total_cnt.
  - Sample sc_tail into the readback register at position bit_cnt.
- SHIFT exit:
  - If total_cnt reaches CHAIN_LEN → DONE.
  - Else if bit_cnt reaches WORD_WIDTH → FETCH.
- Partial last word: when CHAIN_LEN mod WORD_WIDTH = r ≠ 0, only the low r bits of the final word are shifted. Its upper bits are ignored.
- Readback:
  - rb_valid pulses the cycle after the WORD_WIDTH-th bit of a word, or after the final bit.
  - Unfilled upper bits of a partial readback word are 0.
  - There is no backpressure on readback.
- DONE: done=1 for exactly one cycle, then IDLE. busy is high in FETCH, SHIFT and DONE.
- Chain ordering: the first bit shifted ends in the flip-flop farthest from the head. The readback stream is the previous chain contents, tail first.
- Abort (any non-IDLE state):
  - Next state is IDLE and sc_en=0 from the next cycle.
  - No done, no rb_valid.
  - Chain contents are left partially shifted.
- Start while busy is ignored.
- Start and abort in the same cycle in IDLE: abort wins, so the block stays IDLE.
- Reset asserted mid-operation clears all state immediately. Outputs go to 0 asynchronously.

## Timing
- All outputs are registered. sc_en and sc_head change only on clk edges.
- A word handshake completes on the edge where word_valid & word_ready. The first bit of that word appears on sc_head/sc_en in the next cycle.
- Per word cost: 1 FETCH cycle (minimum) + WORD_WIDTH SHIFT cycles. The last word costs 1 + r cycles.
- Minimum load length, with word_valid held high: 1 (IDLE→FETCH) + ceil(CHAIN_LEN/WORD_WIDTH) + CHAIN_LEN cycles, plus 1 DONE cycle.
- sc_tail is sampled on the same edge on which the chain shifts. It must reflect the last flip-flop's value before that edge.
- rb_valid and the completing done pulse are coincident for the final word.

## Test plan
- WORD_WIDTH=8, CHAIN_LEN=16, words 0xA5 then 0x3C, word_valid held high, behavioural 16-bit chain model:
  - After done, the model holds 0x3CA5, with the first bit shifted in the far end.
  - busy is high 19 cycles; done pulses exactly once.
- CHAIN_LEN=20, words 0xFF, 0x00, 0xF7:
  - Exactly 20 sc_en cycles.
  - The last 4 bits shifted are 0x7; the 0xF upper nibble never appears on sc_head.
  - The third rb_valid carries a zero-padded upper nibble.
- Readback: preload the chain model with 0x1234 (CHAIN_LEN=16), then load 0x0000:
  - rb_data sequence is 0x34, then 0x12.
  - The chain ends at 0x0000.
- Stalls: word_valid deasserted 5 cycles between words:
  - word_ready stays high throughout; sc_en stays 0 during the stall.
  - Final chain contents are unchanged versus the no-stall run.
- Abort after 5 SHIFT cycles:
  - IDLE next cycle; sc_en=0 thereafter.
  - No done, no rb_valid.
  - A later start performs a full clean load.
- Reset low mid-SHIFT:
  - All outputs read 0 asynchronously (before the next edge).
  - After reset release, start is accepted and the load completes normally.
